// File: rtl/pwr_pkg.sv
// Shared types and constants for the per-peripheral power-state controller.
// State encodings are consumed by cfg_regs for status and IRQ generation.
package pwr_pkg;

  typedef enum logic [1:0] {
    PwrOff    = 2'b00,
    PwrActive = 2'b01,
    PwrIdle   = 2'b10,
    PwrSleep  = 2'b11
  } pwr_state_e;

  typedef enum logic [1:0] {
    PhDown  = 2'b00,
    PhSlept = 2'b01,
    PhUp    = 2'b10
  } pwr_phase_e;

  localparam int unsigned DefaultIdleTh = 1000;

endpackage

// File: rtl/pwr_chan_fsm.sv
// One power-state channel: OFF/ACTIVE/IDLE/SLEEP FSM, idle counter, switch handshake.
// Optional adaptive sleep threshold predictor enabled by PSC_ADAPTIVE_TH_EN.
module pwr_chan_fsm
  import pwr_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] idle_base_th,
  input  logic [3:0]   alpha,
  input  logic         wake_mask,
  input  logic         act,
  input  logic         wake_in,
  input  logic         pwr_ack,
  output logic [1:0]   state,
  output logic         clk_en,
  output logic         pwr_req
);

  pwr_state_e   state_q;
  pwr_phase_e   phase_q;
  logic [W-1:0] cnt_q;
  logic         pend_q;
  logic         clk_en_q;
  logic         pwr_req_q;

  logic         wake;
  logic [W:0]   cnt_inc;
  logic [W-1:0] cnt_sat;
  logic [W-1:0] sleep_th;
  logic         idle_hit;
  logic         sleep_hit;

  assign wake    = act | (wake_in & wake_mask);
  assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[W-1:0];

  // >= rather than == so a threshold lowered below the running count fires at once
  assign idle_hit  = (idle_base_th != '0) && (cnt_inc >= {1'b0, idle_base_th});
  assign sleep_hit = (sleep_th != '0) && (cnt_inc >= {1'b0, sleep_th});

`ifdef PSC_ADAPTIVE_TH_EN
  logic [W-1:0]        pred_q;
  logic [W-1:0]        dwell_q;
  logic [W-1:0]        pred_nxt;
  logic [W-1:0]        half_th;
  logic                back_to_active;
  logic signed [W+5:0] diff;
  logic signed [W+5:0] delta;
  logic signed [W+5:0] sum;

  always_comb begin
    back_to_active = en && ((state_q == PwrIdle && wake) ||
                            (state_q == PwrSleep && phase_q == PhUp && pwr_ack));
    diff  = $signed({6'd0, dwell_q}) - $signed({6'd0, pred_q});
    delta = (diff * $signed({{(W + 2){1'b0}}, alpha})) >>> 4;
    sum   = $signed({6'd0, pred_q}) + delta;
    if (sum < 0) begin
      pred_nxt = '0;
    end else if (|sum[W+5:W]) begin
      pred_nxt = '1;
    end else begin
      pred_nxt = sum[W-1:0];
    end
    half_th = idle_base_th >> 1;
    if (idle_base_th == '0) begin
      sleep_th = '0;
    end else if (pred_q >= idle_base_th) begin
      sleep_th = (half_th == '0) ? {{(W - 1){1'b0}}, 1'b1} : half_th;
    end else begin
      sleep_th = idle_base_th;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q  <= '0;
      dwell_q <= '0;
    end else begin
      if (back_to_active) pred_q <= pred_nxt;
      if (state_q == PwrActive) begin
        dwell_q <= '0;
      end else if (!(&dwell_q)) begin
        dwell_q <= dwell_q + {{(W - 1){1'b0}}, 1'b1};
      end
    end
  end
`else
  logic unused_alpha;
  assign unused_alpha = ^alpha;
  assign sleep_th     = idle_base_th;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PwrOff;
      phase_q   <= PhDown;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      pwr_req_q <= 1'b0;
    end else if (!en) begin
      state_q   <= PwrOff;
      phase_q   <= PhDown;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      pwr_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        PwrOff: begin
          if (phase_q == PhUp) begin
            if (pwr_ack) begin
              state_q  <= PwrActive;
              clk_en_q <= 1'b1;
              cnt_q    <= '0;
            end
          end else if (!pwr_ack) begin
            pwr_req_q <= 1'b1;
            phase_q   <= PhUp;
          end
        end
        PwrActive: begin
          if (wake) begin
            cnt_q <= '0;
          end else if (idle_hit) begin
            state_q  <= PwrIdle;
            clk_en_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_sat;
          end
        end
        PwrIdle: begin
          if (wake) begin
            state_q  <= PwrActive;
            clk_en_q <= 1'b1;
            cnt_q    <= '0;
          end else if (sleep_hit) begin
            state_q   <= PwrSleep;
            phase_q   <= PhDown;
            pwr_req_q <= 1'b0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_sat;
          end
        end
        PwrSleep: begin
          unique case (phase_q)
            PhDown: begin
              // Wake is deferred until the domain has actually powered down
              if (wake) pend_q <= 1'b1;
              if (!pwr_ack) phase_q <= PhSlept;
            end
            PhSlept: begin
              if (wake || pend_q) begin
                pwr_req_q <= 1'b1;
                phase_q   <= PhUp;
                pend_q    <= 1'b0;
              end
            end
            PhUp: begin
              if (pwr_ack) begin
                state_q  <= PwrActive;
                clk_en_q <= 1'b1;
                cnt_q    <= '0;
              end
            end
            default: phase_q <= PhDown;
          endcase
        end
        default: state_q <= PwrOff;
      endcase
    end
  end

  assign state   = state_q;
  assign clk_en  = clk_en_q;
  assign pwr_req = pwr_req_q;

endmodule

// File: rtl/pwr_state_ctrl.sv
// Per-peripheral power-state controller: N independent pwr_chan_fsm channels.
// Build with PSC_ADAPTIVE_TH_EN to enable the adaptive sleep-threshold predictor.
module pwr_state_ctrl
  import pwr_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   periph_en,
  input  logic [N*W-1:0] idle_base_th,
  input  logic [3:0]     alpha,
  input  logic [N-1:0]   wake_mask,
  input  logic [N-1:0]   act,
  input  logic [N-1:0]   wake_in,
  input  logic [N-1:0]   pwr_ack,
  output logic [2*N-1:0] state,
  output logic [N-1:0]   clk_en,
  output logic [N-1:0]   pwr_req
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    pwr_chan_fsm #(
      .W (W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (periph_en[i]),
      .idle_base_th (idle_base_th[i*W +: W]),
      .alpha        (alpha),
      .wake_mask    (wake_mask[i]),
      .act          (act[i]),
      .wake_in      (wake_in[i]),
      .pwr_ack      (pwr_ack[i]),
      .state        (state[2*i +: 2]),
      .clk_en       (clk_en[i]),
      .pwr_req      (pwr_req[i])
    );
  end

endmodule

// File: tb/tb_pwr_state_ctrl.sv
// Directed self-checking bench for pwr_state_ctrl (default build, N=4, W=16).
module tb_pwr_state_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   periph_en;
  logic [N*W-1:0] idle_base_th;
  logic [3:0]     alpha;
  logic [N-1:0]   wake_mask;
  logic [N-1:0]   act;
  logic [N-1:0]   wake_in;
  logic [N-1:0]   pwr_ack;
  logic [2*N-1:0] state;
  logic [N-1:0]   clk_en;
  logic [N-1:0]   pwr_req;

  int checks = 0;
  int errors = 0;

  pwr_state_ctrl #(
    .N (N),
    .W (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .periph_en    (periph_en),
    .idle_base_th (idle_base_th),
    .alpha        (alpha),
    .wake_mask    (wake_mask),
    .act          (act),
    .wake_in      (wake_in),
    .pwr_ack      (pwr_ack),
    .state        (state),
    .clk_en       (clk_en),
    .pwr_req      (pwr_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_th(input int idx, input logic [W-1:0] val);
    idle_base_th[idx*W +: W] = val;
  endtask

  initial begin
    rst_n = 1'b0; periph_en = '0; idle_base_th = '0; alpha = '0;
    wake_mask = '0; act = '0; wake_in = '0; pwr_ack = '0;
    #3;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_clk_en", 32'(clk_en), 32'h0);
    chk("rst_pwr_req", 32'(pwr_req), 32'h0);
    #9 rst_n = 1'b1;
    step(1);
    chk("off_idle", 32'(state), 32'h0);

    // Power-up of channels 0 and 1, ack three cycles after the request
    set_th(0, 16'd5);
    act       = 4'b0011;
    periph_en = 4'b0011;
    step(1);
    chk("req_after_en", 32'(pwr_req), 32'h3);
    chk("off_wait_ack", 32'(state), 32'h0);
    step(2);
    chk("no_active_before_ack", 32'(clk_en), 32'h0);
    pwr_ack = 4'b0011;
    step(1);
    chk("active_state", 32'(state), 32'h05);
    chk("active_clk_en", 32'(clk_en), 32'h3);

    // Idle count with an act pulse on the third idle cycle
    act = '0;
    step(2);
    act[0] = 1'b1;
    step(1);
    act[0] = 1'b0;
    step(4);
    chk("active_before_th", 32'(state[1:0]), 32'h1);
    step(1);
    chk("idle_after_th", 32'(state[1:0]), 32'h2);
    chk("idle_clk_en", 32'(clk_en[0]), 32'h0);
    chk("idle_pwr_req", 32'(pwr_req[0]), 32'h1);

    // IDLE -> SLEEP with threshold 4
    set_th(0, 16'd4);
    step(3);
    chk("idle_mid", 32'(state[1:0]), 32'h2);
    step(1);
    chk("sleep_state", 32'(state[1:0]), 32'h3);
    chk("sleep_pwr_req", 32'(pwr_req[0]), 32'h0);
    chk("sleep_clk_en", 32'(clk_en[0]), 32'h0);

    // Masked wake is ignored both while powering down and once slept
    wake_in[0] = 1'b1; wake_mask[0] = 1'b0;
    step(2);
    pwr_ack[0] = 1'b0;
    step(3);
    chk("masked_wake_req", 32'(pwr_req[0]), 32'h0);
    chk("masked_wake_state", 32'(state[1:0]), 32'h3);
    wake_mask[0] = 1'b1;
    step(1);
    chk("wake_req", 32'(pwr_req[0]), 32'h1);
    chk("wake_up_state", 32'(state[1:0]), 32'h3);
    wake_in[0] = 1'b0;
    pwr_ack[0] = 1'b1;
    step(1);
    chk("wake_active", 32'(state[1:0]), 32'h1);
    chk("wake_clk_en", 32'(clk_en[0]), 32'h1);

    // Second sleep entry, then a wake pulse while ack is still high
    step(4);
    chk("idle_again", 32'(state[1:0]), 32'h2);
    step(4);
    chk("sleep_again", 32'(state[1:0]), 32'h3);
    wake_in[0] = 1'b1;
    step(1);
    wake_in[0] = 1'b0;
    step(2);
    chk("latched_no_req", 32'(pwr_req[0]), 32'h0);
    pwr_ack[0] = 1'b0;
    step(1);
    chk("slept_no_req_yet", 32'(pwr_req[0]), 32'h0);
    step(1);
    chk("pending_req", 32'(pwr_req[0]), 32'h1);
    chk("pending_state", 32'(state[1:0]), 32'h3);

    // Disable during the UP phase aborts the handshake
    periph_en[0] = 1'b0;
    step(1);
    chk("abort_state", 32'(state[1:0]), 32'h0);
    chk("abort_pwr_req", 32'(pwr_req[0]), 32'h0);
    chk("abort_clk_en", 32'(clk_en[0]), 32'h0);
    chk("ch1_state", 32'(state[3:2]), 32'h1);
    chk("ch1_clk_en", 32'(clk_en[1]), 32'h1);
    chk("ch1_pwr_req", 32'(pwr_req[1]), 32'h1);

    // th=0 keeps channel 1 active; lowering th below the count fires at once
    step(1000);
    chk("th0_stays_active", 32'(state[3:2]), 32'h1);
    set_th(1, 16'd10);
    step(1);
    chk("th_lowered_idle", 32'(state[3:2]), 32'h2);

    // Asynchronous reset mid-count in IDLE
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'h0);
    chk("async_rst_clk_en", 32'(clk_en), 32'h0);
    chk("async_rst_pwr_req", 32'(pwr_req), 32'h0);
    #5 rst_n = 1'b1;
    step(1);
    chk("post_rst_state", 32'(state), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
